// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states, index sizing.
// Pure declarations; no logic, no latency, no flow control.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble build still needs a 1-bit index so the select logic stays uniform.
  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_cin.sv
// 4-bit ripple-carry adder slice with carry-in, built from gate-level full adders.
// Latency: purely combinational; backpressure: none (no handshake).
module nibble_add_cin
  import nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0]   c;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign p[i]   = x[i] ^ y[i];
    assign g[i]   = x[i] & y[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder reusing one 4-bit slice; NIBBLES ADD cycles then a 1-cycle done pulse.
// start is sampled only in IDLE and never queued; NIBBLE_SERIAL_SUB_EN adds the sub port (A - B).
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W:0]   sum
);

  localparam int            IW   = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic [IW-1:0]       idx;
  logic                carry;
  logic                sub_q;
  logic                sub_in;
  logic                last;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B per nibble, seed the carry with sub.
  always_comb begin
    nib_a = op_a[NIBBLE_W*int'(idx) +: NIBBLE_W];
    nib_b = op_b[NIBBLE_W*int'(idx) +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
    last  = (idx == LAST);
  end

  nibble_add_cin u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      sub_q <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            sub_q <= sub_in;
            idx   <= '0;
            carry <= sub_in;
            sum   <= '0;
          end
        end
        ADD: begin
          sum[NIBBLE_W*int'(idx) +: NIBBLE_W] <= slice_s;
          carry <= slice_c;
          if (last) begin
            sum[W] <= slice_c;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench: 4-nibble and 1-nibble instances, hand-computed sums, timing and reset abort.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [16:0] sum;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        sub;
  logic        sub1;
`endif

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        busy1;
  logic        done1;
  logic [4:0]  sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation on the 4-nibble instance with cycle-exact busy/done checks.
  task automatic op4(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                     input logic [16:0] exp, input string tag);
    @(negedge clk);
    a = ta;
    b = tb_v;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = ts;
`else
    if (ts) $display("[TB] sub requested without NIBBLE_SERIAL_SUB_EN: %s", tag);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"}, {15'd0, sum}, {15'd0, exp});
    @(negedge clk);
    chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {15'd0, sum}, {15'd0, exp});
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub    = 1'b0;
    sub1   = 1'b0;
`endif
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {15'd0, sum}, 32'd0);
    chk("rst_sum1", {27'd0, sum1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    op4(16'h1234, 16'h4321, 1'b0, 17'h05555, "add_basic");
    op4(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "add_ripple");
    op4(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, "add_max");

    // start held high: back-to-back results every 6 cycles, a changed mid-flight.
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0002;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_busy1", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("hold_done1", {31'd0, done}, 32'd1);
    chk("hold_sum1", {15'd0, sum}, 32'h00003);
    @(negedge clk);
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_idle_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("hold_busy2", {31'd0, busy}, 32'd1);
    a = 16'h0F00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_busy2", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("hold_done2", {31'd0, done}, 32'd1);
    chk("hold_sum2", {15'd0, sum}, 32'h00003);
    start = 1'b0;
    a = 16'h0000;
    @(negedge clk);
    chk("hold_end_done", {31'd0, done}, 32'd0);

    // Reset during the second ADD cycle aborts without a done pulse.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    chk("abort_sum_pre", {15'd0, sum}, 32'h00005);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {15'd0, sum}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
    end
    op4(16'h00FF, 16'h0001, 1'b0, 17'h00100, "after_abort");

`ifdef NIBBLE_SERIAL_SUB_EN
    op4(16'h0005, 16'h0003, 1'b1, 17'h10002, "sub_pos");
    op4(16'h0003, 16'h0005, 1'b1, 17'h0FFFE, "sub_neg");
    op4(16'h1234, 16'h4321, 1'b0, 17'h05555, "sub_off");
`endif

    // Single-nibble instance: one ADD cycle, then done.
    @(negedge clk);
    a1 = 4'hF;
    b1 = 4'h1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", {31'd0, busy1}, 32'd1);
    chk("n1_nodone", {31'd0, done1}, 32'd0);
    @(negedge clk);
    chk("n1_done", {31'd0, done1}, 32'd1);
    chk("n1_busy_lo", {31'd0, busy1}, 32'd0);
    chk("n1_sum", {27'd0, sum1}, 32'h10);
    @(negedge clk);
    chk("n1_done_lo", {31'd0, done1}, 32'd0);
    chk("n1_hold", {27'd0, sum1}, 32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
